regfile_nr1w_clr: RTL and testbench

- Parametrised, clocked successor to the 2R1W 32x32 toysram register file.
- Configurable width, depth and read-port count; binary addresses replace predecoded ones.
- Registered, valid-qualified read data; optional same-cycle write-to-read bypass.
- Hardware clear sequencer initialises every entry after reset or on request.
- Intended as the drop-in behavioural/synthesizable array for test-site and core register files.

---
 rtl/regfile_nr1w_clr.sv | 147 ++++++++++++++
 tb/tb_regfile_nr1w_clr.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_nr1w_clr.sv
// Parametrised N-read / 1-write register file with registered, valid-qualified reads
// and a hardware clear sequencer that initialises every entry after reset or on request.
module regfile_nr1w_clr #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 32,
    parameter int               NRD      = 2,
    parameter bit               BYPASS   = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VAL = '0,
    localparam int              AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_req,
    output logic                 busy,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_dat,
    output logic [NRD-1:0]       rd_vld,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_dat,
    output logic                 wr_drop
);

    typedef enum logic {
        ST_CLR = 1'b0,
        ST_RDY = 1'b1
    } state_t;

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);

    state_t               state_q, state_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 wr_drop_q, wr_drop_d;
    logic [NRD-1:0]       rd_vld_q, rd_vld_d;
    logic [NRD*WIDTH-1:0] rd_dat_q, rd_dat_d;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic                 mem_we_s;
    logic [AW-1:0]        mem_wa_s;
    logic [WIDTH-1:0]     mem_wd_s;

    // DEPTH need not be a power of two, so the top of the address space can be unmapped.
    function automatic logic in_range(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DEPTH_W);
    endfunction

    // Sequencer: clear walk in ST_CLR, user writes in ST_RDY; selects the single array write.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        wr_drop_d = 1'b0;
        mem_we_s  = 1'b0;
        mem_wa_s  = cnt_q;
        mem_wd_s  = INIT_VAL;
        case (state_q)
            ST_CLR: begin
                mem_we_s  = 1'b1;
                wr_drop_d = wr_en;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RDY;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d  = cnt_q + ONE;
                    busy_d = 1'b1;
                end
            end
            ST_RDY: begin
                mem_we_s = wr_en & in_range(wr_addr);
                mem_wa_s = wr_addr;
                mem_wd_s = wr_dat;
                if (init_req) begin
                    state_d = ST_CLR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_CLR;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // Read ports: sample in ST_RDY only; data holds when a port is idle.
    always_comb begin
        logic [AW-1:0] ra;
        ra       = '0;
        rd_vld_d = '0;
        rd_dat_d = rd_dat_q;
        for (int p = 0; p < NRD; p++) begin
            ra = rd_addr[p*AW +: AW];
            if ((state_q == ST_RDY) && rd_en[p]) begin
                rd_vld_d[p] = 1'b1;
                if (!in_range(ra)) begin
                    rd_dat_d[p*WIDTH +: WIDTH] = '0;
                end else if (BYPASS && wr_en && (wr_addr == ra)) begin
                    rd_dat_d[p*WIDTH +: WIDTH] = wr_dat;
                end else begin
                    rd_dat_d[p*WIDTH +: WIDTH] = mem_q[ra];
                end
            end else begin
                rd_vld_d[p] = 1'b0;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLR;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            wr_drop_q <= 1'b0;
            rd_vld_q  <= '0;
            rd_dat_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            wr_drop_q <= wr_drop_d;
            rd_vld_q  <= rd_vld_d;
            rd_dat_q  <= rd_dat_d;
        end
    end

    // Storage array; contents are established by the clear walk rather than by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_wa_s] <= mem_wd_s;
        end
    end

    assign busy    = busy_q;
    assign wr_drop = wr_drop_q;
    assign rd_vld  = rd_vld_q;
    assign rd_dat  = rd_dat_q;

endmodule

// File: tb/tb_regfile_nr1w_clr.sv
// Scoreboard bench for regfile_nr1w_clr: two 32x32x2 instances (bypass on/off) sharing
// stimulus, plus a 20-entry 8-bit 3-port instance.
module tb_regfile_nr1w_clr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        init_req;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_dat;

    logic        a_busy, a_wr_drop, b_busy, b_wr_drop;
    logic [63:0] a_rd_dat, b_rd_dat;
    logic [1:0]  a_rd_vld, b_rd_vld;

    logic        c_init_req, c_wr_en, c_busy, c_wr_drop;
    logic [2:0]  c_rd_en, c_rd_vld;
    logic [14:0] c_rd_addr;
    logic [4:0]  c_wr_addr;
    logic [7:0]  c_wr_dat;
    logic [23:0] c_rd_dat;

    regfile_nr1w_clr #(.WIDTH(32), .DEPTH(32), .NRD(2), .BYPASS(1'b1), .INIT_VAL(32'h0)) u_a (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(a_busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_dat(a_rd_dat), .rd_vld(a_rd_vld),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_dat(wr_dat), .wr_drop(a_wr_drop));

    regfile_nr1w_clr #(.WIDTH(32), .DEPTH(32), .NRD(2), .BYPASS(1'b0), .INIT_VAL(32'h0)) u_b (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(b_busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_dat(b_rd_dat), .rd_vld(b_rd_vld),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_dat(wr_dat), .wr_drop(b_wr_drop));

    regfile_nr1w_clr #(.WIDTH(8), .DEPTH(20), .NRD(3), .BYPASS(1'b1), .INIT_VAL(8'h0)) u_c (
        .clk(clk), .rst_n(rst_n), .init_req(c_init_req), .busy(c_busy),
        .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_dat(c_rd_dat), .rd_vld(c_rd_vld),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_dat(c_wr_dat), .wr_drop(c_wr_drop));

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] qa0[$], qa1[$], qb0[$], qb1[$];
    logic [7:0]  qc0[$], qc1[$], qc2[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got rd_vld=1 expected no read outstanding", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic measure_clear(output int la, output int lb, output int lc);
        la = 0; lb = 0; lc = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (!a_busy && la == 0) la = k;
            if (!b_busy && lb == 0) lb = k;
            if (!c_busy && lc == 0) lc = k;
        end
    endtask

    // Monitor: every valid read beat is matched against the oldest expectation for its port.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_rd_vld[0]) begin if (qa0.size() == 0) unexp("A.rd0"); else chk("A.rd0", {32'h0, a_rd_dat[31:0]},  {32'h0, qa0.pop_front()}); end
            if (a_rd_vld[1]) begin if (qa1.size() == 0) unexp("A.rd1"); else chk("A.rd1", {32'h0, a_rd_dat[63:32]}, {32'h0, qa1.pop_front()}); end
            if (b_rd_vld[0]) begin if (qb0.size() == 0) unexp("B.rd0"); else chk("B.rd0", {32'h0, b_rd_dat[31:0]},  {32'h0, qb0.pop_front()}); end
            if (b_rd_vld[1]) begin if (qb1.size() == 0) unexp("B.rd1"); else chk("B.rd1", {32'h0, b_rd_dat[63:32]}, {32'h0, qb1.pop_front()}); end
            if (c_rd_vld[0]) begin if (qc0.size() == 0) unexp("C.rd0"); else chk("C.rd0", {56'h0, c_rd_dat[7:0]},   {56'h0, qc0.pop_front()}); end
            if (c_rd_vld[1]) begin if (qc1.size() == 0) unexp("C.rd1"); else chk("C.rd1", {56'h0, c_rd_dat[15:8]},  {56'h0, qc1.pop_front()}); end
            if (c_rd_vld[2]) begin if (qc2.size() == 0) unexp("C.rd2"); else chk("C.rd2", {56'h0, c_rd_dat[23:16]}, {56'h0, qc2.pop_front()}); end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int la, lb, lc, m;
        rst_n = 1'b0; init_req = 1'b0; rd_en = 2'b00; rd_addr = 10'h0;
        wr_en = 1'b0; wr_addr = 5'h0; wr_dat = 32'h0;
        c_init_req = 1'b0; c_rd_en = 3'b000; c_rd_addr = 15'h0;
        c_wr_en = 1'b0; c_wr_addr = 5'h0; c_wr_dat = 8'h0;

        // Reset values
        tick();
        chk("rst.a_busy", 64'(a_busy), 64'h1);
        chk("rst.a_vld", 64'(a_rd_vld), 64'h0);
        chk("rst.a_dat", a_rd_dat, 64'h0);
        chk("rst.a_drop", 64'(a_wr_drop), 64'h0);
        chk("rst.c_busy", 64'(c_busy), 64'h1);
        chk("rst.c_dat", 64'(c_rd_dat), 64'h0);
        tick(); tick();
        rst_n = 1'b1;
        chk("rel.a_busy", 64'(a_busy), 64'h1);
        measure_clear(la, lb, lc);
        chk("clr.a_len", 64'(la), 64'd32);
        chk("clr.b_len", 64'(lb), 64'd32);
        chk("clr.c_len", 64'(lc), 64'd20);

        // Every entry reads back the clear value
        for (int i = 0; i < 16; i++) begin
            rd_en = 2'b11;
            rd_addr = {5'(2*i+1), 5'(2*i)};
            qa0.push_back(32'h0); qa1.push_back(32'h0);
            qb0.push_back(32'h0); qb1.push_back(32'h0);
            tick();
        end
        rd_en = 2'b00;
        tick();

        // Write then read on two ports
        wr_en = 1'b1; wr_addr = 5'd5; wr_dat = 32'hDEADBEEF;
        tick();
        wr_addr = 5'd31; wr_dat = 32'h12345678;
        tick();
        wr_en = 1'b0;
        rd_en = 2'b11; rd_addr = {5'd31, 5'd5};
        qa0.push_back(32'hDEADBEEF); qa1.push_back(32'h12345678);
        qb0.push_back(32'hDEADBEEF); qb1.push_back(32'h12345678);
        tick();
        chk("wr.a_vld", 64'(a_rd_vld), 64'h3);
        rd_en = 2'b00;
        tick();
        chk("hold.a_vld", 64'(a_rd_vld), 64'h0);
        chk("hold.a_dat", a_rd_dat, 64'h12345678_DEADBEEF);

        // Same-cycle write/read collision on entry 7 holding 0x1
        wr_en = 1'b1; wr_addr = 5'd7; wr_dat = 32'h00000001;
        tick();
        wr_dat = 32'hA5A5A5A5;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
        qa0.push_back(32'hA5A5A5A5); qb0.push_back(32'h00000001);
        tick();
        wr_en = 1'b0;
        qa0.push_back(32'hA5A5A5A5); qb0.push_back(32'hA5A5A5A5);
        tick();
        rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
        qa0.push_back(32'hDEADBEEF); qa1.push_back(32'hDEADBEEF);
        qb0.push_back(32'hDEADBEEF); qb1.push_back(32'hDEADBEEF);
        tick();
        rd_en = 2'b00;
        tick();

        // Re-init with a read in the request cycle; writes and reads while busy
        init_req = 1'b1; rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
        qa0.push_back(32'hDEADBEEF); qb0.push_back(32'hDEADBEEF);
        tick();
        init_req = 1'b0;
        chk("init.a_busy", 64'(a_busy), 64'h1);
        m = 0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_dat = 32'hFFFFFFFF;
        rd_en = 2'b11; rd_addr = {5'd31, 5'd5};
        tick(); m++;
        wr_en = 1'b0; rd_en = 2'b00;
        chk("init.a_drop", 64'(a_wr_drop), 64'h1);
        chk("init.b_drop", 64'(b_wr_drop), 64'h1);
        chk("init.a_vld", 64'(a_rd_vld), 64'h0);
        tick(); m++;
        chk("init.a_drop_end", 64'(a_wr_drop), 64'h0);
        while (a_busy && m < 100) begin
            tick();
            m++;
        end
        chk("init.a_len", 64'(m), 64'd32);
        chk("init.b_busy", 64'(b_busy), 64'h0);
        rd_en = 2'b11; rd_addr = {5'd31, 5'd5};
        qa0.push_back(32'h0); qa1.push_back(32'h0);
        qb0.push_back(32'h0); qb1.push_back(32'h0);
        tick();
        rd_en = 2'b00;
        tick();

        // Load non-zero read data, then reset in the middle of a clear
        wr_en = 1'b1; wr_addr = 5'd3; wr_dat = 32'h33333333;
        tick();
        wr_en = 1'b0;
        rd_en = 2'b11; rd_addr = {5'd3, 5'd3};
        qa0.push_back(32'h33333333); qa1.push_back(32'h33333333);
        qb0.push_back(32'h33333333); qb1.push_back(32'h33333333);
        tick();
        rd_en = 2'b00;
        tick();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("mid.a_busy", 64'(a_busy), 64'h1);
        chk("mid.a_dat", a_rd_dat, 64'h0);
        chk("mid.b_dat", b_rd_dat, 64'h0);
        chk("mid.a_vld", 64'(a_rd_vld), 64'h0);
        tick(); tick();
        rst_n = 1'b1;
        measure_clear(la, lb, lc);
        chk("mid.a_len", 64'(la), 64'd32);
        chk("mid.b_len", 64'(lb), 64'd32);
        chk("mid.c_len", 64'(lc), 64'd20);

        // Odd-depth instance
        c_wr_en = 1'b1; c_wr_addr = 5'd19; c_wr_dat = 8'h3C;
        tick();
        c_wr_dat = 8'hC3;
        tick();
        c_wr_addr = 5'd25; c_wr_dat = 8'h77;
        tick();
        c_wr_en = 1'b0;
        c_rd_en = 3'b111; c_rd_addr = {5'd19, 5'd19, 5'd19};
        qc0.push_back(8'hC3); qc1.push_back(8'hC3); qc2.push_back(8'hC3);
        tick();
        c_rd_addr = {5'd24, 5'd0, 5'd25};
        qc0.push_back(8'h00); qc1.push_back(8'h00); qc2.push_back(8'h00);
        tick();
        c_wr_en = 1'b1; c_wr_addr = 5'd0; c_wr_dat = 8'h5A;
        c_rd_en = 3'b010; c_rd_addr = {5'd0, 5'd0, 5'd0};
        qc1.push_back(8'h5A);
        tick();
        c_wr_en = 1'b0; c_rd_en = 3'b000;
        tick(); tick();

        chk("end.qa0", 64'(qa0.size()), 64'h0);
        chk("end.qa1", 64'(qa1.size()), 64'h0);
        chk("end.qb0", 64'(qb0.size()), 64'h0);
        chk("end.qb1", 64'(qb1.size()), 64'h0);
        chk("end.qc0", 64'(qc0.size()), 64'h0);
        chk("end.qc1", 64'(qc1.size()), 64'h0);
        chk("end.qc2", 64'(qc2.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
